// File: rtl/axi4lite_cmd_sequencer.sv
// Command FIFO + issue FSM in front of the 2-bit/8-bit AXI4-Lite master; one transaction in flight.
// Optional WAIT-state timeout is compiled in when SEQ_TIMEOUT_EN is defined.
module axi4lite_cmd_sequencer #(
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [DATA_W-1:0]       cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_we,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic                    mst_start_write,
    output logic [ADDR_W-1:0]       mst_write_addr,
    output logic [DATA_W-1:0]       mst_wdata,
    output logic                    mst_start_read,
    output logic [ADDR_W-1:0]       mst_read_addr,
    input  logic [DATA_W-1:0]       mst_read_data,
    input  logic                    mst_done,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_next;

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              push, pop, complete;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;

`ifdef SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]   to_cnt;
    logic              timed_out;
`else
    logic              unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // cmd_ready depends only on the registered level, never on rsp_ready
    assign cmd_ready = (fifo_level != LVL_W'(DEPTH));
    assign push      = cmd_valid & cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_we, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_we    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
        end else if (pop) begin
            {cur_we, cur_addr, cur_wdata} <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        complete   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        timed_out  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // a done arriving together with the start pulse still completes the command
                if (mst_done) begin
                    complete   = 1'b1;
                    state_next = RESP;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mst_done) begin
                    complete   = 1'b1;
                    state_next = RESP;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    timed_out  = 1'b1;
                    state_next = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          to_cnt <= '0;
        else if (state == ISSUE)             to_cnt <= '0;
        else if (state == WAIT && !mst_done) to_cnt <= to_cnt + TO_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         rsp_err <= 1'b0;
        else if (complete)  rsp_err <= 1'b0;
        else if (timed_out) rsp_err <= 1'b1;
    end
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
        end else if (complete) begin
            rsp_we    <= cur_we;
            rsp_rdata <= cur_we ? '0 : mst_read_data;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (timed_out) begin
            rsp_we    <= cur_we;
            rsp_rdata <= '0;
        end
`endif
    end

    assign rsp_valid       = (state == RESP);
    assign mst_start_write = (state == ISSUE) &  cur_we;
    assign mst_start_read  = (state == ISSUE) & ~cur_we;
    assign mst_write_addr  = cur_addr;
    assign mst_read_addr   = cur_addr;
    assign mst_wdata       = cur_wdata;
    assign busy            = (state != IDLE) | (fifo_level != '0);
endmodule

// File: doc/axi4lite_cmd_sequencer.md
Name: axi4lite_cmd_sequencer

Overview:
- Command-queue controller that drives the user interface of the 2-bit-address, 8-bit-data AXI4-Lite master.
- Buffers read/write commands from a host-side requester in a small FIFO and issues them to the master one at a time.
- Waits for the master's done pulse, then returns one response per command: write ack, or read data.
- Sits between the top-level pin decode logic and the master instance.

Parameters:
- ADDR_W, 2, address width; matches the master's write_addr/read_addr.
- DATA_W, 8, data width; matches the master's write/read data.
- DEPTH, 4, command FIFO entries; must be a power of 2, ≥2.
- TIMEOUT, 15, WAIT-state cycle limit; used only with SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full; a push occurs on cmd_valid & cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target register address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  response held until accepted.
- rsp_ready  in  1  response consumer ready.
- rsp_we  out  1  echo of the command type.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  timeout flag; constant 0 without SEQ_TIMEOUT_EN.
- mst_start_write  out  1  single-cycle write start to the master.
- mst_write_addr  out  ADDR_W  write address to the master.
- mst_wdata  out  DATA_W  write data to the master.
- mst_start_read  out  1  single-cycle read start to the master.
- mst_read_addr  out  ADDR_W  read address to the master.
- mst_read_data  in  DATA_W  read data from the master.
- mst_done  in  1  single-cycle completion pulse from the master.
- busy  out  1  high when state ≠ IDLE or FIFO non-empty.
- fifo_level  out  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, immediate):
  - All outputs 0 except cmd_ready = 1.
  - FIFO pointers and level cleared; state = IDLE; latched command cleared.
  - Reset mid-transaction discards the queue and the in-flight command without any response.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH.
  - cmd_ready = (fifo_level != DEPTH), registered-equivalent, with no combinational path from rsp_ready.
  - Push and pop in the same cycle leave the level unchanged; allowed at any level below DEPTH.
  - A push when full is impossible because cmd_ready is low.
  - A pop when empty never occurs.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO non-empty, pop the head into the command register (we/addr/wdata) and go to ISSUE next cycle. Otherwise stay.
  - ISSUE: for exactly one cycle assert mst_start_write (we = 1) or mst_start_read (we = 0), then go to WAIT.
    - mst_write_addr, mst_wdata and mst_read_addr are driven from the command register and stay stable from ISSUE through RESP.
    - A mst_done in the ISSUE cycle is accepted as completion.
  - WAIT: on mst_done, capture mst_read_data (reads) or 0 (writes) into rsp_rdata, set rsp_valid = 1 and rsp_we, then go to RESP.
  - RESP: hold rsp_* stable while rsp_valid & !rsp_ready. On rsp_ready, clear rsp_valid and go to IDLE.
  - mst_done in IDLE or RESP is ignored.
- Latency: a command pushed into an empty FIFO with the FSM in IDLE produces its start pulse 2 cycles after the push edge (pop cycle, then ISSUE).
- Minimum command-to-command spacing is start → done latency + 3 cycles: ISSUE, RESP and IDLE each take one cycle.
- Strict FIFO order; exactly one outstanding master transaction at any time.
- mst_start_write and mst_start_read are never asserted together.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without mst_done.
  - When it reaches TIMEOUT, go to RESP with rsp_err = 1 and rsp_rdata = 0.
  - A late mst_done is ignored under the standard RESP/IDLE rule.
  - rsp_err = 0 on every normal completion.
- Not defined: no counter; WAIT waits indefinitely; rsp_err tied to 0.

Test Plan:
- Reset, then push write (addr = 2, data = 0xA5):
  - 2 cycles later mst_start_write pulses once, with mst_write_addr = 2 and mst_wdata = 0xA5.
  - After mst_done, rsp_valid = 1, rsp_we = 1, rsp_rdata = 0.
- Push read (addr = 1); the model returns 0x3C with done 3 cycles after the start pulse:
  - mst_start_read pulses once with mst_read_addr = 1.
  - The response shows rsp_we = 0 and rsp_rdata = 0x3C.
- Push 5 commands back-to-back with done stalled:
  - The first is popped; 4 fill the FIFO, fifo_level = 4, cmd_ready = 0.
  - On release, responses come in push order and fifo_level drains to 0.
- Hold rsp_ready = 0 for 6 cycles after a read completes:
  - rsp_valid and rsp_rdata stay stable.
  - No new start pulse occurs until 2 cycles after rsp_ready rises (IDLE pops, then ISSUE).
- Deassert rst_n during WAIT with 2 commands queued:
  - Outputs clear asynchronously; fifo_level = 0; no responses.
  - cmd_ready = 1 on the first cycle after release.
- With SEQ_TIMEOUT_EN and TIMEOUT = 15, issue a read and never pulse done:
  - After 15 WAIT cycles, rsp_valid = 1 and rsp_err = 1.
  - A subsequent stray mst_done produces no extra response.
